// File: rtl/z80_bus_ctrl.sv
// z80_bus_ctrl: Z80 bus controller with wait-state FSM, byte RAM, 4-deep output FIFO and status port.
// Optional feature macro WAIT_STATE_EN: when defined, accesses insert WAIT_CYCLES wait states and a write
// to a full FIFO stalls the CPU; when undefined, WAIT stays low and writes to a full FIFO set OVERFLOW.
module z80_bus_ctrl #(
  parameter int          MEM_AW      = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [7:0]  OUT_PORT    = 8'h00,
  parameter logic [7:0]  STAT_PORT   = 8'h01
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] ADDR,
  input  logic [7:0]  DO,
  output logic [7:0]  DI,
  input  logic        MREQ,
  input  logic        IORQ,
  input  logic        WR,
  input  logic        M1,
  output logic        WAIT,
  output logic [7:0]  PORT_DATA,
  output logic        PORT_VALID,
  input  logic        PORT_READY,
  output logic        OVERFLOW
);
  typedef enum logic [1:0] {IDLE, WAITING, DONE} state_t;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_t      state;
  logic [3:0]  cnt;
  logic [7:0]  ram [2**MEM_AW];
  logic [7:0]  fifo [4];
  logic [1:0]  rd, wr;
  logic [2:0]  count;
  logic        strobe, out_wr, full, do_acc, push, pop, mem_we;
  logic [7:0]  rdata;
  logic        unused;
  assign unused = ^{M1, ADDR};
  assign PORT_VALID = count != 3'd0;
  assign PORT_DATA = fifo[rd];
  // Access decode; the access happens on the edge where do_acc is high, and never while reset is held.
  always_comb begin
    strobe = MREQ || IORQ;
    out_wr = IORQ && !MREQ && WR && ADDR[7:0] == OUT_PORT;
    full = count == 3'd4;
`ifdef WAIT_STATE_EN
    do_acc = RESET && !(out_wr && full) &&
             ((state == IDLE && strobe && WC == 4'd0) || (state == WAITING && cnt == 4'd1));
`else
    do_acc = RESET && state == IDLE && strobe;
`endif
    mem_we = do_acc && MREQ && WR;
    push = do_acc && out_wr && !full;
    pop = PORT_VALID && PORT_READY;
    rdata = MREQ ? ram[ADDR[MEM_AW-1:0]] :
            ADDR[7:0] == STAT_PORT ? {3'b000, OVERFLOW, full, count} : 8'hFF;
  end
  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge CLK)
    if (mem_we) ram[ADDR[MEM_AW-1:0]] <= DO;
  // Bus FSM: one access per strobe assertion, wait-state counting, read data and overflow flag.
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state <= IDLE;
      DI <= 8'h00;
      WAIT <= 1'b0;
      cnt <= 4'd0;
      OVERFLOW <= 1'b0;
    end else begin
      if (do_acc && !WR) DI <= rdata;
      if (do_acc && out_wr && full) OVERFLOW <= 1'b1;
      case (state)
        IDLE:
          if (strobe) begin
            cnt <= WC;
            if (do_acc) state <= DONE;
            else begin
              state <= WAITING;
              WAIT <= 1'b1;
              if (WC == 4'd0) cnt <= 4'd1;
            end
          end
        WAITING:
          if (do_acc) begin
            state <= DONE;
            WAIT <= 1'b0;
            cnt <= 4'd0;
          end else if (cnt != 4'd1) cnt <= cnt - 4'd1;
        default:
          if (!strobe) state <= IDLE;
      endcase
    end
  // Output FIFO; fullness is judged on the registered count so a same-cycle pop never admits a push.
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      for (int i = 0; i < 4; i++) fifo[i] <= 8'h00;
      rd <= 2'd0;
      wr <= 2'd0;
      count <= 3'd0;
    end else begin
      if (push) begin
        fifo[wr] <= DO;
        wr <= wr + 2'd1;
      end
      if (pop) rd <= rd + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
endmodule

// File: tb/tb_z80_bus_ctrl.sv
// tb_z80_bus_ctrl: directed bench with a transaction-level model of RAM, FIFO queue and status flags.
module tb_z80_bus_ctrl;
  logic        clk = 0, rst_n = 0, mreq = 0, iorq = 0, wr = 0, m1 = 0, ready = 0;
  logic [15:0] addr = 0;
  logic [7:0]  dout = 0;
  logic [7:0]  din, pdata;
  logic        wt, pvalid, ovf;
  int          checks = 0, errors = 0;
  logic [7:0]  q[$];
  logic [7:0]  ram_m [256];
  logic [7:0]  exp_di = 0, popped;
  logic        exp_wait = 0, exp_ovf = 0;
`ifdef WAIT_STATE_EN
  localparam int MW = 2;
`else
  localparam int MW = 0;
`endif

  always #5 clk = ~clk;

  z80_bus_ctrl #(.MEM_AW(8), .WAIT_CYCLES(2), .OUT_PORT(8'h00), .STAT_PORT(8'h01)) dut (
    .CLK(clk), .RESET(rst_n), .ADDR(addr), .DO(dout), .DI(din),
    .MREQ(mreq), .IORQ(iorq), .WR(wr), .M1(m1), .WAIT(wt),
    .PORT_DATA(pdata), .PORT_VALID(pvalid), .PORT_READY(ready), .OVERFLOW(ovf)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the downstream consumer: the head leaves whenever ready is high and data exists.
  always @(posedge clk)
    if (rst_n && ready && q.size() > 0) popped = q.pop_front();

  // Cycle-by-cycle comparison of every observable output against the model.
  always @(negedge clk)
    if (rst_n) begin
      chk("wait", {7'b0, wt}, {7'b0, exp_wait});
      chk("di", din, exp_di);
      chk("valid", {7'b0, pvalid}, {7'b0, q.size() > 0});
      if (q.size() > 0) chk("head", pdata, q[0]);
      chk("ovf", {7'b0, ovf}, {7'b0, exp_ovf});
    end

  task automatic model_acc(input logic m, io, w, input logic [15:0] a, input logic [7:0] d,
                           input int sz, input logic ov);
    if (m) begin
      if (w) ram_m[a[7:0]] = d;
      else exp_di = ram_m[a[7:0]];
    end else if (io) begin
      if (w) begin
        if (a[7:0] == 8'h00) begin
          if (sz < 4) q.push_back(d);
          else exp_ovf = 1;
        end
      end else exp_di = (a[7:0] == 8'h01) ? {3'b000, ov, sz == 4, 3'(sz)} : 8'hFF;
    end
  endtask

  task automatic bus(input logic m, io, w, input logic [15:0] a, input logic [7:0] d,
                     input logic rel, output int dw);
    int sz;
    logic ov;
`ifdef WAIT_STATE_EN
    int n;
    logic can;
`endif
    dw = 0;
    mreq = m; iorq = io; wr = w; addr = a; dout = d; m1 = ~w;
`ifdef WAIT_STATE_EN
    @(posedge clk); #1;
    if (wt) dw++;
    exp_wait = 1;
    n = 1;
    forever begin
      sz = q.size();
      ov = exp_ovf;
      can = n >= 2 && !(io && !m && w && a[7:0] == 8'h00 && sz == 4);
      if (rel) ready = (n == 4);
      @(posedge clk); #1;
      n++;
      if (wt) dw++;
      if (can) begin
        model_acc(m, io, w, a, d, sz, ov);
        exp_wait = 0;
        break;
      end
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL timeout waiting for access at %0t", $time);
        break;
      end
    end
`else
    sz = q.size();
    ov = exp_ovf;
    @(posedge clk); #1;
    if (wt) dw++;
    model_acc(m, io, w, a, d, sz, ov);
`endif
    mreq = 0; iorq = 0; wr = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    int dw;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_di", din, 8'h00);
    chk("rst_wait", {7'b0, wt}, 8'h00);
    chk("rst_valid", {7'b0, pvalid}, 8'h00);
    chk("rst_data", pdata, 8'h00);
    chk("rst_ovf", {7'b0, ovf}, 8'h00);
    rst_n = 1;
    bus(1, 0, 1, 16'h0010, 8'h3E, 0, dw);
    chk("wr_waits", 8'(dw), 8'(MW));
    bus(1, 0, 0, 16'h0010, 8'h00, 0, dw);
    chk("rd_waits", 8'(dw), 8'(MW));
    chk("rd_3e", din, 8'h3E);
    bus(1, 0, 0, 16'h0110, 8'h00, 0, dw);
    chk("alias", din, 8'h3E);
    for (int i = 0; i < 5; i++) bus(0, 1, 1, 16'h0000, 8'(8'h0F + i), 1, dw);
`ifdef WAIT_STATE_EN
    chk("stall_waits", 8'(dw), 8'd5);
    chk("head_after_pop", pdata, 8'h10);
    chk("ovf_lit", {7'b0, ovf}, 8'h00);
    bus(0, 1, 0, 16'h0001, 8'h00, 0, dw);
    chk("stat", din, 8'h0C);
`else
    chk("no_waits", 8'(dw), 8'd0);
    chk("head_first", pdata, 8'h0F);
    chk("ovf_lit", {7'b0, ovf}, 8'h01);
    bus(0, 1, 0, 16'h0001, 8'h00, 0, dw);
    chk("stat", din, 8'h1C);
`endif
    bus(0, 1, 0, 16'hAB55, 8'h00, 0, dw);
    chk("io_ff", din, 8'hFF);
    bus(1, 1, 1, 16'h0000, 8'h77, 0, dw);
    chk("memio_fifo", {7'b0, pvalid}, 8'h01);
    bus(1, 0, 0, 16'h0000, 8'h00, 0, dw);
    chk("memio_ram", din, 8'h77);
    bus(0, 1, 1, 16'h0042, 8'h99, 0, dw);
    ready = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("drained", {7'b0, pvalid}, 8'h00);
    ready = 0;
    bus(0, 1, 1, 16'h0000, 8'hA1, 0, dw);
    bus(0, 1, 1, 16'h0000, 8'hA2, 0, dw);
    ready = 1;
    bus(0, 1, 1, 16'h0000, 8'hA3, 0, dw);
`ifndef WAIT_STATE_EN
    chk("pushpop_head", pdata, 8'hA3);
`endif
    ready = 0;
    bus(1, 0, 1, 16'h0020, 8'h5A, 0, dw);
    mreq = 1; wr = 1; addr = 16'h0020; dout = 8'hAA;
`ifdef WAIT_STATE_EN
    @(posedge clk); #3;
`else
    #2;
`endif
    rst_n = 0;
    q.delete();
    exp_di = 0; exp_wait = 0; exp_ovf = 0;
    #1;
    chk("mid_rst_di", din, 8'h00);
    chk("mid_rst_wait", {7'b0, wt}, 8'h00);
    chk("mid_rst_valid", {7'b0, pvalid}, 8'h00);
    chk("mid_rst_data", pdata, 8'h00);
    chk("mid_rst_ovf", {7'b0, ovf}, 8'h00);
    mreq = 0; wr = 0;
    @(posedge clk); #1;
    rst_n = 1;
    bus(1, 0, 0, 16'h0020, 8'h00, 0, dw);
    chk("ram_kept", din, 8'h5A);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
